// File: rtl/xain_rom_dl_sequencer_if.sv
// Host ROM download stream plus the SDRAM ch3 write port, bundled for the download sequencer.
// The sequencer connects through the slave modport; the host/SDRAM side uses master.
interface xain_rom_dl_sequencer_if;
    logic        ioctl_download;
    logic [15:0] ioctl_index;
    logic        ioctl_wr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wait;
    logic [24:0] sdr_addr;
    logic [15:0] sdr_data;
    logic [1:0]  sdr_be;
    logic        sdr_req;
    logic        sdr_rdy;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_data, sdr_rdy,
        input  ioctl_wait, sdr_addr, sdr_data, sdr_be, sdr_req
    );
    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_data, sdr_rdy,
        output ioctl_wait, sdr_addr, sdr_data, sdr_be, sdr_req
    );
endinterface

// File: rtl/xain_rom_dl_sequencer.sv
// ROM download sequencer: packs index-0 bytes into 16-bit SDRAM writes, routes the tail to six BRAM regions.
// Optional build macro ROM_DL_CHECKSUM_EN adds a running mod-2^16 byte checksum output.
module xain_rom_dl_sequencer #(
    parameter logic [24:0] SDR_LIMIT        = 25'h1C0000,
    parameter int          BRAM_REGION_LOG2 = 15,
    parameter logic [24:0] SDR_BASE         = 25'h000000
) (
    input  logic                   CLK,
    input  logic                   RSTn,
    xain_rom_dl_sequencer_if.slave bus,
    output logic [19:0]            bram_addr,
    output logic [7:0]             bram_data,
    output logic [5:0]             bram_cs,
    output logic                   bram_wr,
    output logic                   busy,
    output logic                   done,
`ifdef ROM_DL_CHECKSUM_EN
    output logic [15:0]            checksum,
`endif
    output logic                   overflow
);

    localparam logic [24:0] REGION_MASK = (25'd1 << BRAM_REGION_LOG2) - 25'd1;

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_SDR_REQ, S_SDR_WAIT, S_FLUSH, S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [24:0] offset;
    logic        lo_valid, flushing, skid_vld;
    logic [7:0]  skid_byte;

    logic        in_wait, rdy_evt, start;
    logic        acc_vld, acc_sdr, acc_odd, acc_bram, acc_oor;
    logic [7:0]  acc_byte;
    logic        skid_cap, skid_drop;
    logic [24:0] rel, region;

    assign in_wait = (state == S_SDR_REQ) || (state == S_SDR_WAIT);
    assign rdy_evt = in_wait && bus.sdr_rdy;
    assign start   = (state == S_IDLE) && bus.ioctl_download && (bus.ioctl_index == 16'd0);

    // On write completion the skid byte takes priority over a byte presented in the same cycle.
    always_comb begin
        acc_vld  = 1'b0;
        acc_byte = bus.ioctl_data;
        if (state == S_COLLECT) begin
            acc_vld = bus.ioctl_wr;
        end else if (rdy_evt && !flushing) begin
            if (skid_vld) begin
                acc_vld  = 1'b1;
                acc_byte = skid_byte;
            end else begin
                acc_vld = bus.ioctl_wr;
            end
        end
    end

    assign skid_cap  = in_wait && !rdy_evt && !flushing && bus.ioctl_wr && !skid_vld;
    assign skid_drop = in_wait && !flushing && bus.ioctl_wr && skid_vld;

    assign rel      = offset - SDR_LIMIT;
    assign region   = rel >> BRAM_REGION_LOG2;
    assign acc_sdr  = acc_vld && (offset < SDR_LIMIT);
    assign acc_odd  = acc_sdr && offset[0];
    assign acc_bram = acc_vld && !(offset < SDR_LIMIT) && (region < 25'd6);
    assign acc_oor  = acc_vld && !acc_sdr && !acc_bram;

    always_ff @(posedge CLK) begin
        if (!RSTn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_COLLECT;
            S_COLLECT: begin
                if (acc_odd)                  state_nxt = S_SDR_REQ;
                else if (!bus.ioctl_download) state_nxt = S_FLUSH;
            end
            S_SDR_REQ, S_SDR_WAIT: begin
                if (bus.sdr_rdy) begin
                    if (flushing)     state_nxt = S_DONE;
                    else if (acc_odd) state_nxt = S_SDR_REQ;
                    else              state_nxt = S_COLLECT;
                end else begin
                    state_nxt = S_SDR_WAIT;
                end
            end
            S_FLUSH:   state_nxt = lo_valid ? S_SDR_REQ : S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.sdr_req    = in_wait;
        bus.ioctl_wait = in_wait;
        done           = (state == S_DONE);
        busy           = (state != S_IDLE) || in_wait;
    end

    always_ff @(posedge CLK) begin
        if (skid_cap) skid_byte <= bus.ioctl_data;
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            offset       <= '0;
            lo_valid     <= 1'b0;
            flushing     <= 1'b0;
            skid_vld     <= 1'b0;
            overflow     <= 1'b0;
            bus.sdr_addr <= '0;
            bus.sdr_data <= '0;
            bus.sdr_be   <= '0;
            bram_addr    <= '0;
            bram_data    <= '0;
            bram_cs      <= '0;
            bram_wr      <= 1'b0;
`ifdef ROM_DL_CHECKSUM_EN
            checksum     <= '0;
`endif
        end else begin
            bram_wr <= 1'b0;
            if (start) begin
                offset   <= '0;
                lo_valid <= 1'b0;
                flushing <= 1'b0;
                skid_vld <= 1'b0;
                overflow <= 1'b0;
`ifdef ROM_DL_CHECKSUM_EN
                checksum <= '0;
`endif
            end
            if (acc_vld) offset <= offset + 25'd1;
            if (acc_sdr && !offset[0]) begin
                bus.sdr_addr <= SDR_BASE + {offset[24:1], 1'b0};
                bus.sdr_data <= {8'h00, acc_byte};
                lo_valid     <= 1'b1;
            end
            if (acc_odd) begin
                bus.sdr_data[15:8] <= acc_byte;
                bus.sdr_be         <= 2'b11;
                lo_valid           <= 1'b0;
            end
            if (acc_bram) begin
                bram_wr   <= 1'b1;
                bram_cs   <= 6'd1 << region[2:0];
                bram_addr <= 20'(rel & REGION_MASK);
                bram_data <= acc_byte;
            end
`ifdef ROM_DL_CHECKSUM_EN
            if (acc_sdr || acc_bram) checksum <= checksum + {8'h00, acc_byte};
`endif
            if (acc_oor || skid_drop) overflow <= 1'b1;
            if (skid_cap)     skid_vld <= 1'b1;
            else if (rdy_evt) skid_vld <= 1'b0;
            // A trailing even byte goes out alone with only the low lane enabled.
            if (state == S_FLUSH && lo_valid) begin
                flushing           <= 1'b1;
                lo_valid           <= 1'b0;
                bus.sdr_be         <= 2'b01;
                bus.sdr_data[15:8] <= 8'h00;
            end
            if (state == S_DONE) flushing <= 1'b0;
        end
    end

endmodule

// File: tb/tb_xain_rom_dl_sequencer.sv
// Directed bench for xain_rom_dl_sequencer with a small SDR_LIMIT and 16-byte BRAM regions.
// Build with ROM_DL_CHECKSUM_EN defined to also cover the checksum output.
module tb_xain_rom_dl_sequencer;

    localparam logic [24:0] LIMIT = 25'h000008;
    localparam int          LOG2  = 4;

    logic clk;
    logic rstn;
    logic [19:0] bram_addr;
    logic [7:0]  bram_data;
    logic [5:0]  bram_cs;
    logic        bram_wr;
    logic        busy;
    logic        done;
    logic        overflow;
`ifdef ROM_DL_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    int checks = 0;
    int errors = 0;

    xain_rom_dl_sequencer_if dl_if ();

    xain_rom_dl_sequencer #(
        .SDR_LIMIT       (LIMIT),
        .BRAM_REGION_LOG2(LOG2),
        .SDR_BASE        (25'h000000)
    ) dut (
        .CLK      (clk),
        .RSTn     (rstn),
        .bus      (dl_if),
        .bram_addr(bram_addr),
        .bram_data(bram_data),
        .bram_cs  (bram_cs),
        .bram_wr  (bram_wr),
        .busy     (busy),
        .done     (done),
`ifdef ROM_DL_CHECKSUM_EN
        .checksum (checksum),
`endif
        .overflow (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        dl_if.ioctl_wr   = 1'b1;
        dl_if.ioctl_data = b;
        tick();
        dl_if.ioctl_wr   = 1'b0;
    endtask

    task automatic start_dl();
        dl_if.ioctl_index    = 16'd0;
        dl_if.ioctl_download = 1'b1;
        tick();
    endtask

    // Waits for a write request, checks it, then answers with sdr_rdy dly cycles after req rose.
    task automatic sdr_serve(input string tag, input logic [24:0] a, input logic [15:0] d,
                             input logic [1:0] be, input int dly);
        int n = 0;
        while (!dl_if.sdr_req && n < 20) begin
            tick();
            n++;
        end
        chk({tag, " req"},  32'(dl_if.sdr_req),    1);
        chk({tag, " addr"}, 32'(dl_if.sdr_addr),   32'(a));
        chk({tag, " data"}, 32'(dl_if.sdr_data),   32'(d));
        chk({tag, " be"},   32'(dl_if.sdr_be),     32'(be));
        chk({tag, " wait"}, 32'(dl_if.ioctl_wait), 1);
        repeat (dly - 1) tick();
        chk({tag, " hold"}, 32'(dl_if.sdr_req), 1);
        dl_if.sdr_rdy = 1'b1;
        tick();
        dl_if.sdr_rdy = 1'b0;
        chk({tag, " req drop"},  32'(dl_if.sdr_req),    0);
        chk({tag, " wait drop"}, 32'(dl_if.ioctl_wait), 0);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 30) begin
            tick();
            n++;
        end
        chk({tag, " done"}, 32'(done), 1);
        tick();
        chk({tag, " done once"}, 32'(done), 0);
        chk({tag, " idle"},      32'(busy), 0);
    endtask

    initial begin
        dl_if.ioctl_download = 1'b0;
        dl_if.ioctl_index    = 16'd0;
        dl_if.ioctl_wr       = 1'b0;
        dl_if.ioctl_data     = 8'h00;
        dl_if.sdr_rdy        = 1'b0;
        rstn = 1'b0;
        repeat (3) tick();
        chk("rst sdr_req",  32'(dl_if.sdr_req),    0);
        chk("rst wait",     32'(dl_if.ioctl_wait), 0);
        chk("rst busy",     32'(busy),             0);
        chk("rst done",     32'(done),             0);
        chk("rst overflow", 32'(overflow),         0);
        chk("rst bram_wr",  32'(bram_wr),          0);
        chk("rst bram_cs",  32'(bram_cs),          0);
        chk("rst sdr_addr", 32'(dl_if.sdr_addr),   0);
        chk("rst sdr_data", 32'(dl_if.sdr_data),   0);
        rstn = 1'b1;
        tick();

        // Non-zero index is ignored.
        dl_if.ioctl_index    = 16'd5;
        dl_if.ioctl_download = 1'b1;
        repeat (3) tick();
        chk("idx5 busy", 32'(busy), 0);
        dl_if.ioctl_download = 1'b0;
        dl_if.ioctl_index    = 16'd0;
        tick();

        // Four bytes, two full words.
        start_dl();
        chk("t1 busy", 32'(busy), 1);
        send_byte(8'h11);
        send_byte(8'h22);
        sdr_serve("t1 w0", 25'h000000, 16'h2211, 2'b11, 3);
        send_byte(8'h33);
        send_byte(8'h44);
        sdr_serve("t1 w1", 25'h000002, 16'h4433, 2'b11, 3);
        dl_if.ioctl_download = 1'b0;
        wait_done("t1");

        // Odd byte count: trailing half-word flush.
        start_dl();
        send_byte(8'hAA);
        send_byte(8'hBB);
        sdr_serve("t2 w0", 25'h000000, 16'hBBAA, 2'b11, 2);
        send_byte(8'hCC);
        dl_if.ioctl_download = 1'b0;
        sdr_serve("t2 flush", 25'h000002, 16'h00CC, 2'b01, 2);
        wait_done("t2");

        // Skid captures one byte under backpressure, the next is dropped.
        start_dl();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        chk("t3 overflow", 32'(overflow),         1);
        chk("t3 wait",     32'(dl_if.ioctl_wait), 1);
        sdr_serve("t3 w0", 25'h000000, 16'h2211, 2'b11, 1);
        dl_if.ioctl_download = 1'b0;
        sdr_serve("t3 flush", 25'h000002, 16'h0033, 2'b01, 2);
        wait_done("t3");
        chk("t3 overflow sticky", 32'(overflow), 1);
        start_dl();
        chk("t3 overflow cleared", 32'(overflow), 0);
        dl_if.ioctl_download = 1'b0;
        wait_done("t3 empty");

        // Reset during a pending write.
        start_dl();
        send_byte(8'h55);
        send_byte(8'h66);
        sdr_serve("t4 w0", 25'h000000, 16'h6655, 2'b11, 1);
        send_byte(8'h77);
        send_byte(8'h88);
        chk("t4 req pending", 32'(dl_if.sdr_req), 1);
        rstn = 1'b0;
        dl_if.ioctl_download = 1'b0;
        tick();
        chk("t4 rst req",  32'(dl_if.sdr_req),    0);
        chk("t4 rst wait", 32'(dl_if.ioctl_wait), 0);
        chk("t4 rst busy", 32'(busy),             0);
        chk("t4 rst addr", 32'(dl_if.sdr_addr),   0);
        rstn = 1'b1;
        dl_if.sdr_rdy = 1'b1;
        tick();
        dl_if.sdr_rdy = 1'b0;
        chk("t4 late rdy req",  32'(dl_if.sdr_req), 0);
        chk("t4 late rdy busy", 32'(busy),          0);
        chk("t4 late rdy done", 32'(done),          0);
        start_dl();
        send_byte(8'h99);
        send_byte(8'hAA);
        sdr_serve("t4 restart", 25'h000000, 16'hAA99, 2'b11, 2);
        dl_if.ioctl_download = 1'b0;
        wait_done("t4");

        // BRAM regions after SDR_LIMIT (8): 16-byte regions, six of them.
        start_dl();
        for (int i = 0; i < 8; i++) begin
            send_byte(8'(i));
            if (i % 2 == 1)
                sdr_serve("t5 sdr", 25'(i - 1), {8'(i), 8'(i - 1)}, 2'b11, 1);
        end
        send_byte(8'hA5);
        chk("t5 r0 wr",   32'(bram_wr),          1);
        chk("t5 r0 cs",   32'(bram_cs),          32'h01);
        chk("t5 r0 addr", 32'(bram_addr),        0);
        chk("t5 r0 data", 32'(bram_data),        32'hA5);
        chk("t5 r0 wait", 32'(dl_if.ioctl_wait), 0);
        tick();
        chk("t5 wr pulse", 32'(bram_wr), 0);
        for (int off = 9; off <= 'h19; off++) send_byte(8'(off));
        chk("t5 r1 wr",   32'(bram_wr),   1);
        chk("t5 r1 cs",   32'(bram_cs),   32'h02);
        chk("t5 r1 addr", 32'(bram_addr), 1);
        chk("t5 r1 data", 32'(bram_data), 32'h19);
        for (int off = 'h1A; off <= 'h67; off++) send_byte(8'(off));
        chk("t5 r5 cs",      32'(bram_cs),   32'h20);
        chk("t5 r5 addr",    32'(bram_addr), 32'hF);
        chk("t5 r5 no ovf",  32'(overflow),  0);
        send_byte(8'h68);
        chk("t5 oor ovf",    32'(overflow),      1);
        chk("t5 oor no wr",  32'(bram_wr),       0);
        chk("t5 no sdr_req", 32'(dl_if.sdr_req), 0);
        dl_if.ioctl_download = 1'b0;
        wait_done("t5");

`ifdef ROM_DL_CHECKSUM_EN
        start_dl();
        send_byte(8'hFF);
        send_byte(8'hFF);
        sdr_serve("t6 w0", 25'h000000, 16'hFFFF, 2'b11, 1);
        send_byte(8'h02);
        dl_if.ioctl_download = 1'b0;
        sdr_serve("t6 flush", 25'h000002, 16'h0002, 2'b01, 1);
        chk("t6 checksum at done", 32'(checksum), 32'h0200);
        wait_done("t6");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
